// File: rtl/gigatron_video_out.sv
// rtl/gigatron_video_out.sv - Gigatron OUT/XOUT registers, VGA colour expansion and sync timing monitor
// Optional build macro: BLANK_WHEN_UNLOCKED_EN (forces RGB to black while timing is not locked).
module gigatron_video_out #(
   parameter int LINE_CLKS   = 800,
   parameter int LINE_TOL    = 8,
   parameter int FRAME_LINES = 521,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Out_We,
   input  logic [7:0] i_Out_Data,
   input  logic [7:0] i_Acc,
   output logic [2:0] o_VGA_Red,
   output logic [2:0] o_VGA_Grn,
   output logic [2:0] o_VGA_Blu,
   output logic       o_VGA_HSync,
   output logic       o_VGA_VSync,
   output logic [7:0] o_Xout,
   output logic       o_Locked,
   output logic [9:0] o_Line_Count
);

   typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

   localparam logic [11:0] PER_MAX   = 12'hFFF;
   localparam logic [9:0]  LINE_MAX  = 10'h3FF;
   // Line count is the zero-based index of the current line, so a full frame ends on FRAME_LINES-1.
   localparam logic [9:0]  LAST_LINE = 10'(FRAME_LINES - 1);
   localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);
   localparam int          PER_LO    = LINE_CLKS - LINE_TOL;
   localparam int          PER_HI    = LINE_CLKS + LINE_TOL;

   state_t      state_q, state_d;
   logic [7:0]  out_q, out_d;
   logic [7:0]  xout_q, xout_d;
   logic [11:0] per_q, per_d;
   logic [9:0]  line_q, line_d;
   logic [7:0]  good_q, good_d;
   logic        bad_q, bad_d;
   logic        armed_q, armed_d;

   logic hs_rise, hs_fall, vs_fall;
   logic line_ok, line_bad, frame_len_ok, timeout, blank;
   logic signed [31:0] per_s;

   assign hs_rise = i_Out_We & ~out_q[6] &  i_Out_Data[6];
   assign hs_fall = i_Out_We &  out_q[6] & ~i_Out_Data[6];
   assign vs_fall = i_Out_We &  out_q[7] & ~i_Out_Data[7];

   assign per_s        = $signed({20'd0, per_q});
   assign line_ok      = (per_s >= PER_LO) && (per_s <= PER_HI);
   assign line_bad     = hs_fall & armed_q & ~line_ok;
   assign frame_len_ok = (line_q == LAST_LINE);
   assign timeout      = (per_q == PER_MAX);

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      armed_d = armed_q | hs_fall;
      out_d   = i_Out_We ? i_Out_Data : out_q;
      xout_d  = hs_rise ? i_Acc : xout_q;
      per_d   = hs_fall ? 12'd1 : (timeout ? per_q : per_q + 12'd1);
      line_d  = line_q;
      if (vs_fall)
         line_d = 10'd0;
      else if (hs_fall && line_q != LINE_MAX)
         line_d = line_q + 10'd1;

      case (state_q)
         S_SEARCH: begin
            if (vs_fall) begin
               state_d = S_MEASURE;
               good_d  = 8'd0;
               bad_d   = 1'b0;
            end
         end
         S_MEASURE: begin
            if (line_bad) bad_d = 1'b1;
            if (vs_fall) begin
               if (bad_q || line_bad || !frame_len_ok) begin
                  state_d = S_SEARCH;
               end else begin
                  good_d = good_q + 8'd1;
                  if (good_q + 8'd1 >= LOCK_N) state_d = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (line_bad || (vs_fall && !frame_len_ok)) state_d = S_SEARCH;
         end
         default: state_d = S_SEARCH;
      endcase

      if (timeout) state_d = S_SEARCH;
      // Dropping back to SEARCH discards the line reference, so the next period is not judged.
      if (timeout || (state_d == S_SEARCH && state_q != S_SEARCH)) armed_d = 1'b0;
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q <= S_SEARCH;
         out_q   <= 8'hC0;
         xout_q  <= 8'd0;
         per_q   <= 12'd0;
         line_q  <= 10'd0;
         good_q  <= 8'd0;
         bad_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         xout_q  <= xout_d;
         per_q   <= per_d;
         line_q  <= line_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         armed_q <= armed_d;
      end
   end

   function automatic logic [2:0] expand(input logic [1:0] c);
      return {c[1], c[0], c[1]};
   endfunction

`ifdef BLANK_WHEN_UNLOCKED_EN
   assign blank = (state_q != S_LOCKED);
`else
   assign blank = 1'b0;
`endif

   assign o_VGA_Red    = blank ? 3'd0 : expand(out_q[1:0]);
   assign o_VGA_Grn    = blank ? 3'd0 : expand(out_q[3:2]);
   assign o_VGA_Blu    = blank ? 3'd0 : expand(out_q[5:4]);
   assign o_VGA_HSync  = out_q[6];
   assign o_VGA_VSync  = out_q[7];
   assign o_Xout       = xout_q;
   assign o_Locked     = (state_q == S_LOCKED);
   assign o_Line_Count = line_q;

endmodule

// File: tb/tb_gigatron_video_out.sv
// tb/tb_gigatron_video_out.sv - directed self-checking bench for gigatron_video_out
module tb_gigatron_video_out;

   localparam int LC  = 32;
   localparam int TOL = 4;
   localparam int FL  = 16;
`ifdef BLANK_WHEN_UNLOCKED_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       out_we = 1'b0;
   logic [7:0] out_data = 8'h00;
   logic [7:0] acc = 8'h00;
   logic [2:0] red, grn, blu;
   logic       hsync, vsync, locked;
   logic [7:0] xout;
   logic [9:0] line_cnt;

   int checks = 0;
   int errors = 0;

   gigatron_video_out #(
      .LINE_CLKS(LC), .LINE_TOL(TOL), .FRAME_LINES(FL), .LOCK_FRAMES(2)
   ) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Out_We(out_we), .i_Out_Data(out_data), .i_Acc(acc),
      .o_VGA_Red(red), .o_VGA_Grn(grn), .o_VGA_Blu(blu),
      .o_VGA_HSync(hsync), .o_VGA_VSync(vsync), .o_Xout(xout),
      .o_Locked(locked), .o_Line_Count(line_cnt)
   );

   always #20 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      out_we = 1'b1;
      out_data = d;
      tick();
      out_we = 1'b0;
   endtask

   task automatic hs_fall_write(input bit vs);
      wr({~vs, 1'b0, 6'h3F});
   endtask

   task automatic line_rest(input int p, input bit vs, input logic [7:0] a);
      repeat (3) tick();
      acc = a;
      wr({~vs, 1'b1, 6'h3F});
      repeat (p - 5) tick();
   endtask

   task automatic drive_line(input int p, input bit vs, input logic [7:0] a);
      hs_fall_write(vs);
      line_rest(p, vs, a);
   endtask

   task automatic drive_frame(input int p);
      for (int i = 0; i < FL; i++) drive_line(p, (i == 0), 8'(i));
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_red", red, 0);
      check("rst_grn", grn, 0);
      check("rst_blu", blu, 0);
      check("rst_xout", xout, 0);
      check("rst_locked", locked, 0);
      check("rst_line_count", line_cnt, 0);

      wr(8'hE1);
      check("e1_red", red, BLANK ? 3'b000 : 3'b010);
      check("e1_grn", grn, 3'b000);
      check("e1_blu", blu, BLANK ? 3'b000 : 3'b101);
      check("e1_hsync", hsync, 1);
      check("e1_vsync", vsync, 1);

      wr(8'hDB);
      check("db_red", red, BLANK ? 3'b000 : 3'b111);
      check("db_grn", grn, BLANK ? 3'b000 : 3'b101);
      check("db_blu", blu, BLANK ? 3'b000 : 3'b010);

      acc = 8'h5A;
      wr(8'h80);
      check("hs_low_xout", xout, 8'h00);
      check("hs_low_hsync", hsync, 0);
      check("hs_low_line_count", line_cnt, 1);
      tick();
      wr(8'hC0);
      check("hs_rise_xout", xout, 8'h5A);

      rst_n = 1'b0;
      out_we = 1'b1;
      out_data = 8'h00;
      tick();
      out_we = 1'b0;
      rst_n = 1'b1;
      check("midrst_hsync", hsync, 1);
      check("midrst_vsync", vsync, 1);
      check("midrst_xout", xout, 0);
      check("midrst_line_count", line_cnt, 0);
      tick();

      drive_frame(LC);
      drive_frame(LC);
      check("f2_line_count", line_cnt, FL - 1);
      check("f2_unlocked", locked, 0);
      drive_frame(LC);
      check("f3_locked", locked, 1);
      check("f3_line_count", line_cnt, FL - 1);
      check("f3_xout", xout, FL - 1);

      drive_line(LC, 1'b1, 8'h00);
      drive_line(LC + TOL, 1'b0, 8'h01);
      drive_line(LC - TOL, 1'b0, 8'h02);
      drive_line(LC + TOL + 1, 1'b0, 8'h03);
      check("tol_edges_locked", locked, 1);
      hs_fall_write(1'b0);
      check("bad_line_unlock", locked, 0);
      line_rest(LC, 1'b0, 8'h04);
      for (int i = 5; i < FL; i++) drive_line(LC, 1'b0, 8'(i));

      drive_frame(LC);
      drive_frame(LC);
      check("relock_pending", locked, 0);
      drive_frame(LC);
      check("relocked", locked, 1);
      check("relock_out_ff_red", red, 3'b111);

      repeat (3900) tick();
      check("pre_timeout_locked", locked, 1);
      repeat (300) tick();
      check("timeout_unlocked", locked, 0);
      check("timeout_hsync", hsync, 1);
      check("timeout_red", red, BLANK ? 3'b000 : 3'b111);
      check("timeout_blu", blu, BLANK ? 3'b000 : 3'b111);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
